// File: rtl/ex_muldiv_unit_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: decoded op codes
// and the sequencing FSM states.
package ex_muldiv_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_DIVU  = 2'b01,
    MD_MTHI  = 2'b10,
    MD_MTLO  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } md_state_e;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Request/result bundle between ID/EX and the multiply/divide unit.
// The master side issues ops; the slave side is the unit itself.
interface ex_muldiv_unit_if
  import ex_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             start;
  md_op_e           op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, op, operand_a, operand_b,
    input  stall, busy, done, hi_out, lo_out
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    output stall, busy, done, hi_out, lo_out
  );
endinterface

// File: rtl/ex_muldiv_unit_md_datapath.sv
// Shift/add multiplier and restoring divider sharing one accumulator and one
// combined multiplier/quotient shift register; one step per enabled cycle.
module md_datapath
  import ex_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  md_op_e           op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] opnd;
  logic             div_op;
  logic             div_zero;

  logic [WIDTH:0]   add;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] mq_next;

  // Next accumulator / shift-register value for one iteration step
  always_comb begin
    add      = {1'b0, acc};
    shifted  = {acc, mq[WIDTH-1]};
    diff     = shifted - {1'b0, opnd};
    acc_next = acc;
    mq_next  = mq;
    if (div_op) begin
      // diff[WIDTH] is the borrow: set means the trial subtraction is restored
      if (!diff[WIDTH]) begin
        acc_next = diff[WIDTH-1:0];
        mq_next  = {mq[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = shifted[WIDTH-1:0];
        mq_next  = {mq[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (mq[0]) begin
        add = {1'b0, acc} + {1'b0, opnd};
      end else begin
        add = {1'b0, acc};
      end
      acc_next = add[WIDTH:1];
      mq_next  = {add[0], mq[WIDTH-1:1]};
    end
  end

  // Operand capture on load, one iteration per step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc      <= {WIDTH{1'b0}};
      mq       <= {WIDTH{1'b0}};
      opnd     <= {WIDTH{1'b0}};
      div_op   <= 1'b0;
      div_zero <= 1'b0;
    end else if (load) begin
      acc      <= {WIDTH{1'b0}};
      mq       <= (op == MD_DIVU) ? operand_a : operand_b;
      opnd     <= (op == MD_DIVU) ? operand_b : operand_a;
      div_op   <= (op == MD_DIVU);
      div_zero <= (operand_b == {WIDTH{1'b0}});
    end else if (step) begin
      acc <= acc_next;
      mq  <= mq_next;
    end
  end

  // With a zero divisor the remainder naturally ends up equal to the dividend
  assign res_hi = acc;
  assign res_lo = (div_op && div_zero) ? {WIDTH{1'b1}} : mq;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative unsigned MULTU/DIVU engine owning the HI/LO pair;
// sequences the datapath and stalls the front end while an op is in flight.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              reset,
  ex_muldiv_unit_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  md_state_e        state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy_flag;
  logic             done_flag;
  logic             accept;
  logic             step;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  // Issue decode: only mul/div ops start the engine, and only from IDLE
  always_comb begin
    accept = 1'b0;
    step   = 1'b0;
    if (state == ST_IDLE) begin
      accept = bus.start && ((bus.op == MD_MULTU) || (bus.op == MD_DIVU));
    end else if (state == ST_BUSY) begin
      step = 1'b1;
    end else begin
      step = 1'b0;
    end
  end

  md_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .step      (step),
    .op        (bus.op),
    .operand_a (bus.operand_a),
    .operand_b (bus.operand_b),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  // Sequencing FSM, iteration counter and architectural HI/LO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      count     <= {CNT_W{1'b0}};
      hi        <= {WIDTH{1'b0}};
      lo        <= {WIDTH{1'b0}};
      busy_flag <= 1'b0;
      done_flag <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              MD_MTHI: hi <= bus.operand_a;
              MD_MTLO: lo <= bus.operand_a;
              MD_MULTU, MD_DIVU: begin
                state     <= ST_BUSY;
                count     <= CNT_W'(WIDTH);
                busy_flag <= 1'b1;
              end
              default: state <= ST_IDLE;
            endcase
          end
        end
        ST_BUSY: begin
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state     <= ST_DONE;
            done_flag <= 1'b1;
          end
        end
        ST_DONE: begin
          hi        <= res_hi;
          lo        <= res_lo;
          state     <= ST_IDLE;
          busy_flag <= 1'b0;
          done_flag <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          busy_flag <= 1'b0;
          done_flag <= 1'b0;
        end
      endcase
    end
  end

  // Stall drops in DONE so the held op leaves ID/EX as HI/LO are written
  assign bus.stall  = accept || (state == ST_BUSY);
  assign bus.busy   = busy_flag;
  assign bus.done   = done_flag;
  assign bus.hi_out = hi;
  assign bus.lo_out = lo;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: vector table plus random ops
// through a result scoreboard, and hand-written MT/reset/toggle sequences.
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  localparam int W = 32;

  typedef struct {
    md_op_e      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   done_cnt;
  logic [63:0] sb_q[$];
  vec_t vecs[10];

  ex_muldiv_unit_if #(.WIDTH(W)) bus ();

  ex_muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: pop and compare whenever the unit retires a result
  always begin
    @(posedge clk);
    if (reset && bus.done) begin
      done_cnt++;
      #1;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: result %h with empty scoreboard", {bus.hi_out, bus.lo_out});
      end else begin
        chk("result", {bus.hi_out, bus.lo_out}, sb_q.pop_front());
      end
    end
  end

  task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo, input bit toggle);
    int n;
    int d0;
    bit bad;
    bit seen;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = op;
    bus.operand_a = a;
    bus.operand_b = b;
    sb_q.push_back({hi, lo});
    d0 = done_cnt;
    #1;
    chk("stall_issue", {63'd0, bus.stall}, 64'd1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n = 0;
    bad = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        bus.start = 1'b0;
        break;
      end
      n++;
      if (!bus.stall || !bus.busy) bad = 1'b1;
      if (toggle) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.op = ($urandom_range(0, 1) == 0) ? MD_MULTU : MD_DIVU;
        bus.operand_a = $urandom;
        bus.operand_b = $urandom;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout: no done within 40 cycles for op %0d", op);
      sb_q.delete();
    end else begin
      chk("busy_cycles", 64'(n), 64'(W));
      chk("stall_busy", {63'd0, bad}, 64'd0);
      chk("stall_done", {62'd0, bus.stall, bus.busy}, 64'd1);
      @(posedge clk);
      #2;
      chk("done_pulses", 64'(done_cnt - d0), 64'd1);
      @(negedge clk);
      chk("idle_after", {61'd0, bus.done, bus.busy, bus.stall}, 64'd0);
    end
  endtask

  initial begin
    vecs[0] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
    vecs[2] = '{MD_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
    vecs[3] = '{MD_MULTU, 32'd7,         32'd9,         32'd0,         32'd63};
    vecs[4] = '{MD_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    vecs[5] = '{MD_DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF};
    vecs[6] = '{MD_DIVU,  32'd3,         32'd10,        32'd3,         32'd0};
    vecs[7] = '{MD_MULTU, 32'h1234_5678, 32'h0000_0100, 32'h0000_0012, 32'h3456_7800};
    vecs[8] = '{MD_DIVU,  32'h8000_0000, 32'h8000_0000, 32'd0,         32'd1};
    vecs[9] = '{MD_MULTU, 32'd0,         32'd5,         32'd0,         32'd0};

    checks = 0;
    errors = 0;
    done_cnt = 0;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.op = MD_MULTU;
    bus.operand_a = 32'd0;
    bus.operand_b = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
    chk("reset_flags", {61'd0, bus.done, bus.busy, bus.stall}, 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b0);
    end

    // Random traffic on start/operands while busy must not disturb the result
    run_op(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    run_op(MD_MULTU, 32'hDEAD_BEEF, 32'h0000_0010, 32'h0000_000D, 32'hEADB_EEF0, 1'b1);

    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [63:0] p;
      ra = $urandom;
      rb = (i == 5) ? 32'd1 + 32'($urandom_range(0, 255)) : $urandom;
      if (i[0]) begin
        run_op(MD_DIVU, ra, rb, ra % rb, ra / rb, 1'b0);
      end else begin
        p = {32'd0, ra} * {32'd0, rb};
        run_op(MD_MULTU, ra, rb, p[63:32], p[31:0], 1'b0);
      end
    end

    // MTHI then MTLO back-to-back: written directly, never stalling
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = MD_MTHI;
    bus.operand_a = 32'h0000_1234;
    #1;
    chk("mthi_stall", {63'd0, bus.stall}, 64'd0);
    @(negedge clk);
    bus.op = MD_MTLO;
    bus.operand_a = 32'h0000_ABCD;
    #1;
    chk("mtlo_stall", {63'd0, bus.stall}, 64'd0);
    chk("mthi_value", {32'd0, bus.hi_out}, 64'h1234);
    @(negedge clk);
    bus.start = 1'b0;
    chk("mt_hilo", {bus.hi_out, bus.lo_out}, {32'h0000_1234, 32'h0000_ABCD});
    chk("mt_flags", {61'd0, bus.done, bus.busy, bus.stall}, 64'd0);

    // Reset at BUSY cycle 10 aborts the op; a reissued op still completes
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = MD_MULTU;
    bus.operand_a = 32'd7;
    bus.operand_b = 32'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_reset_busy", {63'd0, bus.busy}, 64'd1);
    reset = 1'b0;
    #1;
    chk("abort_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
    chk("abort_flags", {61'd0, bus.done, bus.busy, bus.stall}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_op(MD_MULTU, 32'd7, 32'd9, 32'd0, 32'd63, 1'b0);

    repeat (2) @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
